// File: rtl/dodger_datapath.sv
// dodger_datapath: moves the player square, plots it on the VGA pixel port and reports collision/end.
// Define OBSTACLE_PLOT_EN to paint the obstacle rectangle after leaving IDLE.
module dodger_datapath #(
  parameter int SIZE = 4,
  parameter int START_X = 0,
  parameter int START_Y = 56,
  parameter int END_X = 156,
  parameter int OBST_X0 = 80,
  parameter int OBST_X1 = 83,
  parameter int OBST_Y0 = 40,
  parameter int OBST_Y1 = 79,
  parameter int TICK_CYCLES = 833333,
  parameter logic [2:0] OBJ_COLOUR = 3'b111
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       writeEnable,
  input  logic       draw,
  input  logic       setoff,
  input  logic       move_up,
  input  logic       move_down,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       finish
);
  localparam int DW = $clog2(SIZE);
  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  typedef enum logic [3:0] {
    IDLE,
`ifdef OBSTACLE_PLOT_EN
    OBST_DRAW,
`endif
    INIT_DRAW, HOLD, WAIT, ERASE, UPDATE, DRAW, DONE
  } state_t;
  state_t state, nxt;
  logic [2*DW-1:0] k;
  logic [DW-1:0] dx, dy;
  logic [7:0] pos_x, new_x;
  logic [6:0] pos_y, new_y;
  logic [TW-1:0] tick;
  logic stop, sq, paint, k_last, hit, at_end;
  assign {dy, dx} = k;
  assign k_last = &k;
  assign sq = state inside {INIT_DRAW, ERASE, DRAW};
  assign paint = state inside {INIT_DRAW, DRAW};
  assign finish = state == DONE;
  assign new_x = pos_x + 8'd1;
  assign new_y = (move_up && !move_down && pos_y != 7'd0) ? pos_y - 7'd1 :
                 (move_down && !move_up && pos_y < 7'(120 - SIZE)) ? pos_y + 7'd1 : pos_y;
  // 9-bit sums keep the far edge of the square from wrapping
  assign hit = ({1'b0, new_x} + 9'(SIZE - 1) >= 9'(OBST_X0)) && (new_x <= 8'(OBST_X1)) &&
               ({2'b0, new_y} + 9'(SIZE - 1) >= 9'(OBST_Y0)) && (new_y <= 7'(OBST_Y1));
  assign at_end = new_x >= 8'(END_X);
`ifdef OBSTACLE_PLOT_EN
  logic [7:0] ox;
  logic [6:0] oy;
  logic obst;
  assign obst = state == OBST_DRAW;
  assign plot = (sq || obst) && writeEnable && draw;
  assign x = sq ? pos_x + 8'(dx) : obst ? ox : 8'd0;
  assign y = sq ? pos_y + 7'(dy) : obst ? oy : 7'd0;
  assign colour = paint ? OBJ_COLOUR : obst ? 3'b100 : 3'b000;
`else
  assign plot = sq && writeEnable && draw;
  assign x = sq ? pos_x + 8'(dx) : 8'd0;
  assign y = sq ? pos_y + 7'(dy) : 7'd0;
  assign colour = paint ? OBJ_COLOUR : 3'b000;
`endif
  always_comb begin
    nxt = state;
    case (state)
`ifdef OBSTACLE_PLOT_EN
      IDLE:      nxt = draw ? OBST_DRAW : IDLE;
      OBST_DRAW: nxt = (draw && ox == 8'(OBST_X1) && oy == 7'(OBST_Y1)) ? INIT_DRAW : OBST_DRAW;
`else
      IDLE:      nxt = draw ? INIT_DRAW : IDLE;
`endif
      INIT_DRAW: nxt = (draw && k_last) ? HOLD : INIT_DRAW;
      HOLD:      nxt = setoff ? WAIT : HOLD;
      WAIT:      nxt = !setoff ? HOLD : (tick == TICK_LAST) ? ERASE : WAIT;
      ERASE:     nxt = (draw && k_last) ? UPDATE : ERASE;
      UPDATE:    nxt = DRAW;
      DRAW:      nxt = (draw && k_last) ? (stop ? DONE : WAIT) : DRAW;
      default:   nxt = state;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pos_x <= 8'(START_X);
      pos_y <= 7'(START_Y);
      k <= '0;
      tick <= '0;
      stop <= 1'b0;
`ifdef OBSTACLE_PLOT_EN
      ox <= 8'(OBST_X0);
      oy <= 7'(OBST_Y0);
`endif
    end else begin
      state <= nxt;
      if (sq && draw) k <= k + 1'b1;
      tick <= (state == WAIT && setoff && tick != TICK_LAST) ? tick + 1'b1 : '0;
      if (state == UPDATE) begin
        pos_x <= new_x;
        pos_y <= new_y;
        stop <= hit || at_end;
      end
`ifdef OBSTACLE_PLOT_EN
      if (obst && draw) begin
        ox <= (ox == 8'(OBST_X1)) ? 8'(OBST_X0) : ox + 8'd1;
        if (ox == 8'(OBST_X1)) oy <= (oy == 7'(OBST_Y1)) ? 7'(OBST_Y0) : oy + 7'd1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_dodger_datapath.sv
// tb_dodger_datapath: randomized scoreboard bench; a game model predicts every plotted pixel.
module tb_dodger_datapath;
  logic clock = 0, reset = 0, writeEnable = 0, draw = 0, setoff = 0, move_up = 0, move_down = 0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic plot, finish;
  typedef struct packed {logic [7:0] px; logic [6:0] py; logic [2:0] pc;} pix_t;
  pix_t exq[$];
  pix_t e;
  int compared = 0, mismatched = 0, seen = 0;
  bit jitter = 0;

  dodger_datapath #(.TICK_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .writeEnable(writeEnable), .draw(draw), .setoff(setoff),
    .move_up(move_up), .move_down(move_down), .x(x), .y(y), .colour(colour), .plot(plot),
    .finish(finish)
  );

  always #5 clock = ~clock;

  // draw stalls are invisible to the pixel stream, so the model needs no timing
  always @(posedge clock) begin
    #1;
    if (jitter) draw = ($urandom_range(0, 5) != 0);
  end

  always @(negedge clock) if (plot) begin
    seen++;
    compared++;
    if (exq.size() == 0) begin
      mismatched++;
      $display("FAIL unexpected_plot got x=%0d y=%0d colour=%0d", x, y, colour);
    end else begin
      e = exq.pop_front();
      if ({x, y, colour, finish} !== {e, 1'b0}) begin
        mismatched++;
        $display("FAIL pixel got x=%0d y=%0d colour=%0d finish=%0b expected x=%0d y=%0d colour=%0d finish=0",
                 x, y, colour, finish, e.px, e.py, e.pc);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  task automatic wait_seen(input int target, input string nm);
    int n = 0;
    while (seen < target && n < 1000) begin
      @(posedge clock);
      n++;
    end
    if (seen < target) begin
      compared++;
      mismatched++;
      $display("FAIL %s timeout seen=%0d required=%0d", nm, seen, target);
    end
  endtask

  task automatic push_sq(input int px, input int py, input logic [2:0] c);
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++)
        exq.push_back(pix_t'{8'(px + i), 7'(py + j), c});
  endtask

  task automatic do_reset(input string nm);
    jitter = 0;
    @(posedge clock);
    #3 reset = 1;
    exq.delete();
    #1;
    check({nm, "_plot"}, plot, 0);
    check({nm, "_x"}, x, 0);
    check({nm, "_y"}, y, 0);
    check({nm, "_finish"}, finish, 0);
    draw = 0;
    setoff = 0;
    move_up = 0;
    move_down = 0;
    repeat (3) @(posedge clock);
    #3 reset = 0;
  endtask

  function automatic logic [1:0] pick(input int mode);
    return mode == 0 ? 2'b00 : mode == 2 ? 2'b10 : 2'($urandom_range(0, 3));
  endfunction

  // mode 0: no keys, 1: random keys with draw stalls, 2: move_up held
  task automatic run_game(input int mode, input int abort_at);
    int px = 0, py = 56, nx, ny, pushed = 0, base, m = 0;
    bit stop = 0, hit;
    base = seen;
    push_sq(px, py, 3'd7);
    pushed = 16;
    writeEnable = 1;
    draw = 1;
    wait_seen(base + 16, "init_draw");
    repeat (8) @(posedge clock);
    #1;
    check("hold_plot", plot, 0);
    check("hold_finish", finish, 0);
    {move_up, move_down} = pick(mode);
    setoff = 1;
    jitter = (mode == 1);
    while (!stop) begin
      m++;
      push_sq(px, py, 3'd0);
      nx = px + 1;
      ny = py;
      if (move_up && !move_down && py > 0) ny = py - 1;
      else if (move_down && !move_up && py < 116) ny = py + 1;
      hit = nx + 3 >= 80 && nx <= 83 && ny + 3 >= 40 && ny <= 79;
      stop = hit || nx >= 156;
      push_sq(nx, ny, 3'd7);
      px = nx;
      py = ny;
      if (m == abort_at) begin
        wait_seen(base + pushed + 5, "abort_point");
        do_reset("mid_reset");
        return;
      end
      wait_seen(base + pushed + 17, "update");
      pushed += 32;
      {move_up, move_down} = pick(mode);
    end
    wait_seen(base + pushed, "final_square");
    jitter = 0;
    draw = 1;
    repeat (20) @(posedge clock);
    #1;
    check("done_finish", finish, 1);
    check("done_plot", plot, 0);
    check("queue_drained", exq.size(), 0);
  endtask

  initial begin
    do_reset("por");
    run_game(0, 0);
    do_reset("after_hit");
    run_game(1, $urandom_range(5, 40));
    run_game(2, 0);
    do_reset("after_end");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
